// File: rtl/mul_sequencer_pkg.sv
// Shared types and constants for the EX-stage iterative multiplier.
package mul_sequencer_pkg;

    localparam int unsigned MUL_XLEN = 32;

    // EX opcode the control unit decodes to "mul" before driving start_i.
    localparam logic [2:0] EX_OP_MUL = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mul_sequencer_if.sv
// Handshake and operand/result bundle between the EX stage and the mul sequencer.
interface mul_sequencer_if
    import mul_sequencer_pkg::*;
#(
    parameter int unsigned XLEN = MUL_XLEN
) ();

    logic            start_i;
    logic            flush_i;
    logic [XLEN-1:0] op_a_i;
    logic [XLEN-1:0] op_b_i;
    logic            stall_o;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] product_o;

    modport master (
        output start_i, flush_i, op_a_i, op_b_i,
        input  stall_o, busy_o, done_o, product_o
    );

    modport slave (
        input  start_i, flush_i, op_a_i, op_b_i,
        output stall_o, busy_o, done_o, product_o
    );

endinterface

// File: rtl/mul_shift_add_dp.sv
// Shift-add datapath: accumulator, shifting multiplicand and multiplier.
module mul_shift_add_dp
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic            step_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    output logic [XLEN-1:0] acc_nxt_c
);

    logic [XLEN-1:0] acc_q,    acc_d;
    logic [XLEN-1:0] mcand_q,  mcand_d;
    logic [XLEN-1:0] mplier_q, mplier_d;

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        if (load_i) begin
            acc_d    = '0;
            mcand_d  = op_a_i;
            mplier_d = op_b_i;
        end else if (step_i) begin
            // Sum wraps mod 2^XLEN: only the low product half is kept.
            if (mplier_q[0]) acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

    assign acc_nxt_c = acc_d;

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle mul controller: holds the pipeline front while the shift-add runs
// and releases the product with a one-cycle done pulse.
module mul_sequencer
    import mul_sequencer_pkg::*;
#(
    parameter int unsigned XLEN = MUL_XLEN
) (
    input  logic           clk_i,
    input  logic           rst_i,
    mul_sequencer_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(XLEN + 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [XLEN-1:0]  product_q, product_d;
    logic [XLEN-1:0]  acc_nxt;
    logic             load, step, stall, done;

    mul_shift_add_dp #(.XLEN(XLEN)) u_dp (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (load),
        .step_i    (step),
        .op_a_i    (bus.op_a_i),
        .op_b_i    (bus.op_b_i),
        .acc_nxt_c (acc_nxt)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        load      = 1'b0;
        step      = 1'b0;
        stall     = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    load    = 1'b1;
                    stall   = 1'b1;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                step  = 1'b1;
                stall = 1'b1;
                cnt_d = cnt_q + CNT_W'(1);
                // Capture the post-step accumulator so product_o is valid in DONE.
                if (cnt_q == CNT_W'(XLEN - 1)) begin
                    state_d   = DONE;
                    product_d = acc_nxt;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A squash discards whatever is in flight and frees the pipeline.
        if (bus.flush_i) begin
            state_d   = IDLE;
            cnt_d     = cnt_q;
            product_d = product_q;
            load      = 1'b0;
            step      = 1'b0;
            stall     = 1'b0;
            done      = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    // Outputs are forced low during reset, even while the old state is still visible.
    assign bus.stall_o   = stall & ~rst_i;
    assign bus.busy_o    = (state_q == RUN) & ~rst_i;
    assign bus.done_o    = done & ~rst_i;
    assign bus.product_o = product_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed-vector bench for mul_sequencer.
module tb_mul_sequencer;

    localparam int unsigned XLEN = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    mul_sequencer_if #(.XLEN(XLEN)) bus ();

    mul_sequencer #(.XLEN(XLEN)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.start_i = 1'b0; bus.flush_i = 1'b0; bus.op_a_i = '0; bus.op_b_i = '0;
        rst = 1'b1;
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            bus.start_i = 1'($urandom_range(1));
            bus.flush_i = 1'($urandom_range(1));
            bus.op_a_i  = $urandom;
            bus.op_b_i  = $urandom;
            @(negedge clk);
            n_cmp++;
            if ({bus.stall_o, bus.busy_o, bus.done_o} !== 3'b000 || bus.product_o !== 32'd0) begin
                n_err++;
                $display("FAIL reset_hold[%0d] stall/busy/done=%b%b%b product=%h want 000/0",
                         i, bus.stall_o, bus.busy_o, bus.done_o, bus.product_o);
            end
            next_cycle();
        end
        rst = 1'b0; bus.start_i = 1'b0; bus.flush_i = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus.stall_o, bus.busy_o, bus.done_o} !== 3'b000 || bus.product_o !== 32'd0) begin
            n_err++;
            $display("FAIL reset_release stall/busy/done=%b%b%b product=%h want 000/0",
                     bus.stall_o, bus.busy_o, bus.done_o, bus.product_o);
        end
        next_cycle();
    endtask

    // Accepts one mul with start held, runs until done_o, checks timing and result.
    // Returns in the IDLE cycle after DONE with start_i still high.
    task automatic test_one_mul(input string nm, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] prev, input logic [31:0] exp);
        int sc = 0, bc = 0, dc = 0, dn = 0;
        logic [31:0] p = '0;
        logic ds = 1'b1, held = 1'b1;
        bus.start_i = 1'b1; bus.flush_i = 1'b0; bus.op_a_i = a; bus.op_b_i = b;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            if (bus.stall_o) sc++;
            if (bus.busy_o)  bc++;
            if (bus.done_o) begin
                dn++; dc = cyc; p = bus.product_o; ds = bus.stall_o;
            end else if (bus.product_o !== prev) begin
                held = 1'b0;
            end
            next_cycle();
            if (dc != 0) break;
        end
        n_cmp++;
        if (sc != 33) begin n_err++; $display("FAIL %s stall_cycles got %0d want 33", nm, sc); end
        n_cmp++;
        if (bc != 32) begin n_err++; $display("FAIL %s busy_cycles got %0d want 32", nm, bc); end
        n_cmp++;
        if (dc != 34) begin n_err++; $display("FAIL %s done_cycle got %0d want 34", nm, dc); end
        n_cmp++;
        if (ds !== 1'b0) begin n_err++; $display("FAIL %s stall_in_done got %b want 0", nm, ds); end
        n_cmp++;
        if (p !== exp) begin n_err++; $display("FAIL %s product got %h want %h", nm, p, exp); end
        n_cmp++;
        if (held !== 1'b1) begin n_err++; $display("FAIL %s product_held got %b want 1", nm, held); end
    endtask

    task automatic test_basic_and_hold();
        test_one_mul("basic_6x7", 32'd6, 32'd7, 32'd0, 32'd42);
        // start_i was high through DONE; the DONE cycle must not have re-accepted.
        bus.start_i = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus.busy_o, bus.stall_o, bus.done_o} !== 3'b000 || bus.product_o !== 32'd42) begin
            n_err++;
            $display("FAIL hold_through_done busy/stall/done=%b%b%b product=%h want 000/2a",
                     bus.busy_o, bus.stall_o, bus.done_o, bus.product_o);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        test_one_mul("b2b_3x4", 32'd3, 32'd4, 32'd42, 32'd12);
    endtask

    task automatic test_flush();
        int dn = 0;
        bus.start_i = 1'b1; bus.flush_i = 1'b0; bus.op_a_i = 32'd9; bus.op_b_i = 32'd9;
        for (int i = 0; i < 10; i++) next_cycle();
        bus.flush_i = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({bus.stall_o, bus.done_o} !== 2'b00) begin
            n_err++;
            $display("FAIL flush_cycle stall/done=%b%b want 00", bus.stall_o, bus.done_o);
        end
        next_cycle();
        bus.flush_i = 1'b0; bus.start_i = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus.busy_o, bus.stall_o} !== 2'b00 || bus.product_o !== 32'd12) begin
            n_err++;
            $display("FAIL flush_after busy/stall=%b%b product=%h want 00/0000000c",
                     bus.busy_o, bus.stall_o, bus.product_o);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done_o) dn++;
            next_cycle();
        end
        n_cmp++;
        if (dn != 0) begin n_err++; $display("FAIL flush_no_done got %0d done pulses want 0", dn); end
        // flush together with start in IDLE is not an accept.
        bus.start_i = 1'b1; bus.flush_i = 1'b1; bus.op_a_i = 32'd1; bus.op_b_i = 32'd1;
        @(negedge clk);
        n_cmp++;
        if (bus.stall_o !== 1'b0) begin
            n_err++; $display("FAIL flush_start_stall got %b want 0", bus.stall_o);
        end
        next_cycle();
        bus.start_i = 1'b0; bus.flush_i = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.busy_o !== 1'b0 || bus.product_o !== 32'd12) begin
            n_err++;
            $display("FAIL flush_start_accept busy=%b product=%h want 0/0000000c",
                     bus.busy_o, bus.product_o);
        end
        next_cycle();
    endtask

    task automatic test_wrap();
        test_one_mul("wrap_ffff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd12, 32'h0000_0001);
        test_one_mul("wrap_8000x2", 32'h8000_0000, 32'd2, 32'h0000_0001, 32'h0000_0000);
        test_one_mul("zero_mplier", 32'd5, 32'd0, 32'h0000_0000, 32'h0000_0000);
        bus.start_i = 1'b0;
        next_cycle();
    endtask

    task automatic test_reset_midop();
        test_one_mul("pre_reset_6x7", 32'd6, 32'd7, 32'd0, 32'd42);
        bus.start_i = 1'b0;
        next_cycle();
        bus.start_i = 1'b1; bus.op_a_i = 32'd9; bus.op_b_i = 32'd9;
        for (int i = 0; i < 5; i++) next_cycle();
        rst = 1'b1; bus.start_i = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus.stall_o, bus.busy_o, bus.done_o} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_midop_during stall/busy/done=%b%b%b want 000",
                     bus.stall_o, bus.busy_o, bus.done_o);
        end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus.stall_o, bus.busy_o, bus.done_o} !== 3'b000 || bus.product_o !== 32'd0) begin
            n_err++;
            $display("FAIL reset_midop_after stall/busy/done=%b%b%b product=%h want 000/0",
                     bus.stall_o, bus.busy_o, bus.done_o, bus.product_o);
        end
        next_cycle();
        test_one_mul("post_reset_2x3", 32'd2, 32'd3, 32'd0, 32'd6);
        bus.start_i = 1'b0;
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_basic_and_hold();
        test_back_to_back();
        test_flush();
        test_wrap();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
